// File: rtl/alu_logical32_pkg.sv
// Shared definitions for the logical/shift slice of the 32-bit ALU.
package alu_logical32_pkg;

    localparam int unsigned ALU_W   = 32;
    localparam int unsigned SHAMT_W = 5;

    // Full operation select is {sel2, sel1, sel0}.
    localparam logic [2:0] OP_AND     = 3'b000;
    localparam logic [2:0] OP_OR      = 3'b001;
    localparam logic [2:0] OP_XOR     = 3'b010;
    localparam logic [2:0] OP_NOR     = 3'b011;
    localparam logic [2:0] OP_SRA     = 3'b100;
    localparam logic [2:0] OP_SRL     = 3'b101;
    localparam logic [2:0] OP_SLL     = 3'b110;
    localparam logic [2:0] OP_SLL_ALT = 3'b111;

    // Fill mask covering the top 'amt' bits, used for arithmetic right shifts.
    function automatic logic [ALU_W-1:0] top_mask(input int unsigned amt);
        return ~({ALU_W{1'b1}} >> amt);
    endfunction

endpackage

// File: rtl/barrel_shift_32.sv
// Five-stage logarithmic barrel shifter (stages of 1/2/4/8/16 bits).
module barrel_shift_32
    import alu_logical32_pkg::*;
(
    input  logic [ALU_W-1:0]   data_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    input  logic               left_i,
    input  logic               arith_i,
    output logic [ALU_W-1:0]   data_o
);

    logic fill;
    logic [ALU_W-1:0] stage [SHAMT_W+1];

    // Each stage conditionally shifts by a power of two; sign fill only for right arithmetic.
    always_comb begin
        fill     = arith_i & ~left_i & data_i[ALU_W-1];
        stage[0] = data_i;
        for (int s = 0; s < SHAMT_W; s++) begin
            if (!shamt_i[s]) begin
                stage[s+1] = stage[s];
            end else if (left_i) begin
                stage[s+1] = stage[s] << (1 << s);
            end else begin
                stage[s+1] = (stage[s] >> (1 << s)) | (fill ? top_mask(1 << s) : '0);
            end
        end
        data_o = stage[SHAMT_W];
    end

endmodule

// File: rtl/alu_logical32.sv
// Logical and shift slice of the 32-bit ALU; all datapath nodes are registered.
module alu_logical32
    import alu_logical32_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             sel2,
    input  logic             sel1,
    input  logic             sel0,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] logical_32_out,
    output logic [WIDTH-1:0] sll_out,
    output logic [WIDTH-1:0] srl_sra_out,
    output logic [WIDTH-1:0] mux_0_out
);

    logic [ALU_W-1:0] logical_d, sll_d, srl_sra_d, mux_0_d, out_d;
    logic [ALU_W-1:0] logical_q, sll_q, srl_sra_q, mux_0_q, out_q;

    barrel_shift_32 u_shift_left (
        .data_i  (in1),
        .shamt_i (in2[SHAMT_W-1:0]),
        .left_i  (1'b1),
        .arith_i (1'b0),
        .data_o  (sll_d)
    );

    // sel0=0 selects SRA, sel0=1 selects SRL.
    barrel_shift_32 u_shift_right (
        .data_i  (in1),
        .shamt_i (in2[SHAMT_W-1:0]),
        .left_i  (1'b0),
        .arith_i (~sel0),
        .data_o  (srl_sra_d)
    );

    // Logical unit decodes only {sel1, sel0}; final muxing picks the class via sel2.
    always_comb begin
        logical_d = '0;
        unique case ({1'b0, sel1, sel0})
            OP_AND:  logical_d = in1 & in2;
            OP_OR:   logical_d = in1 | in2;
            OP_XOR:  logical_d = in1 ^ in2;
            OP_NOR:  logical_d = ~(in1 | in2);
            default: logical_d = '0;
        endcase
        mux_0_d = sel1 ? sll_d : srl_sra_d;
        out_d   = sel2 ? mux_0_d : logical_d;
    end

    // Single output register stage; reset clears every output immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            logical_q <= '0;
            sll_q     <= '0;
            srl_sra_q <= '0;
            mux_0_q   <= '0;
            out_q     <= '0;
        end else begin
            logical_q <= logical_d;
            sll_q     <= sll_d;
            srl_sra_q <= srl_sra_d;
            mux_0_q   <= mux_0_d;
            out_q     <= out_d;
        end
    end

    assign out            = out_q;
    assign logical_32_out = logical_q;
    assign sll_out        = sll_q;
    assign srl_sra_out    = srl_sra_q;
    assign mux_0_out      = mux_0_q;

endmodule

// File: tb/tb_alu_logical32.sv
// Self-checking bench for alu_logical32: directed table, corner sequences, random pipelined run.
module tb_alu_logical32;

    logic        clk;
    logic        rst_n;
    logic [31:0] in1, in2;
    logic        sel2, sel1, sel0;
    logic [31:0] out, logical_32_out, sll_out, srl_sra_out, mux_0_out;

    int checks   = 0;
    int failures = 0;

    alu_logical32 #(.WIDTH(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in1            (in1),
        .in2            (in2),
        .sel2           (sel2),
        .sel1           (sel1),
        .sel0           (sel0),
        .out            (out),
        .logical_32_out (logical_32_out),
        .sll_out        (sll_out),
        .srl_sra_out    (srl_sra_out),
        .mux_0_out      (mux_0_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_out;
    } vec_t;

    typedef struct {
        logic [31:0] o, lg, sl, sr, m0;
    } res_t;

    // Reference model straight from the operation table.
    function automatic res_t model(input logic [2:0] sel, input logic [31:0] a,
                                   input logic [31:0] b);
        res_t r;
        int unsigned sh;
        sh = b % 32;
        case (sel[1:0])
            2'd0: r.lg = a & b;
            2'd1: r.lg = a | b;
            2'd2: r.lg = a ^ b;
            default: r.lg = ~(a | b);
        endcase
        r.sl = a << sh;
        if (sel[0]) r.sr = a >> sh;
        else        r.sr = 32'($signed(a) >>> sh);
        r.m0 = sel[1] ? r.sl : r.sr;
        r.o  = sel[2] ? r.m0 : r.lg;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input res_t e);
        check({name, ".out"}, out, e.o);
        check({name, ".logical"}, logical_32_out, e.lg);
        check({name, ".sll"}, sll_out, e.sl);
        check({name, ".srl_sra"}, srl_sra_out, e.sr);
        check({name, ".mux0"}, mux_0_out, e.m0);
    endtask

    task automatic drive(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b);
        {sel2, sel1, sel0} = sel;
        in1 = a;
        in2 = b;
    endtask

    // Apply at negedge, sample 1 time unit after the capturing posedge.
    task automatic apply(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        drive(sel, a, b);
        @(posedge clk);
        #1;
    endtask

    res_t zero_r = '{o: 32'h0, lg: 32'h0, sl: 32'h0, sr: 32'h0, m0: 32'h0};
    vec_t tbl[$];
    res_t exp_q[$];

    initial begin
        rst_n = 1'b0;
        drive(3'b010, 32'hDEAD_BEEF, 32'h1234_5678);

        // Reset held with nonzero inputs across clock edges.
        repeat (3) @(posedge clk);
        #1;
        check_all("reset_hold", zero_r);

        @(negedge clk);
        rst_n = 1'b1;

        tbl.push_back('{3'b000, 32'h1,         32'h1,         32'h1});
        tbl.push_back('{3'b001, 32'h1,         32'h1,         32'h1});
        tbl.push_back('{3'b010, 32'h1,         32'h0,         32'h1});
        tbl.push_back('{3'b011, 32'h0,         32'h0,         32'hFFFF_FFFF});
        tbl.push_back('{3'b110, 32'h30,        32'h0,         32'h30});
        tbl.push_back('{3'b100, 32'hF,         32'h0,         32'hF});
        tbl.push_back('{3'b101, 32'hA,         32'h0,         32'hA});
        tbl.push_back('{3'b100, 32'h8000_0010, 32'h4,         32'hF800_0001});
        tbl.push_back('{3'b101, 32'h8000_0010, 32'h4,         32'h0800_0001});
        tbl.push_back('{3'b110, 32'h8000_0010, 32'h4,         32'h0000_0100});
        tbl.push_back('{3'b111, 32'h8000_0010, 32'h4,         32'h0000_0100});
        tbl.push_back('{3'b110, 32'h1,         32'h1F,        32'h8000_0000});
        tbl.push_back('{3'b100, 32'h8000_0000, 32'h1F,        32'hFFFF_FFFF});
        tbl.push_back('{3'b101, 32'h8000_0000, 32'h1F,        32'h0000_0001});
        tbl.push_back('{3'b110, 32'h3,         32'hFFFF_FFE1, 32'h6});

        foreach (tbl[i]) begin
            apply(tbl[i].sel, tbl[i].a, tbl[i].b);
            check($sformatf("vec%0d.out", i), out, tbl[i].exp_out);
            check_all($sformatf("vec%0d", i), model(tbl[i].sel, tbl[i].a, tbl[i].b));
        end

        // Intermediates are computed regardless of the selected operation.
        apply(3'b000, 32'h30, 32'h1);
        check("inter.logical", logical_32_out, 32'h0);
        check("inter.sll", sll_out, 32'h60);
        check("inter.mux0", mux_0_out, 32'h18);
        check("inter.out", out, 32'h0);

        // Between-edge input changes do not reach the outputs.
        @(negedge clk);
        drive(3'b011, 32'h0, 32'h0);
        #1;
        check("no_edge.out", out, 32'h0);

        // Back-to-back ops: every code, one per cycle, each visible exactly one cycle later.
        for (int i = 0; i < 40; i++) begin
            logic [2:0]  s;
            logic [31:0] a, b;
            s = (i < 8) ? 3'(i) : 3'($urandom_range(0, 7));
            a = $urandom;
            b = (i % 5 == 0) ? 32'hFFFF_FFE1 : $urandom;
            @(negedge clk);
            if (exp_q.size() != 0) check_all($sformatf("pipe%0d", i), exp_q.pop_front());
            drive(s, a, b);
            exp_q.push_back(model(s, a, b));
        end
        @(negedge clk);
        check_all("pipe_last", exp_q.pop_front());

        // Mid-stream reset clears outputs without a clock edge.
        drive(3'b011, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        check("pre_rst.out", out, 32'hFFFF_FFFF);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("mid_rst", zero_r);
        @(posedge clk);
        #1;
        check_all("mid_rst_edge", zero_r);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_rel.out", out, 32'h0);
        @(posedge clk);
        #1;
        check_all("post_rst", model(3'b011, 32'h0, 32'h0));

        // Randomised single-op checks.
        for (int i = 0; i < 100; i++) begin
            logic [2:0]  s;
            logic [31:0] a, b;
            s = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            apply(s, a, b);
            check_all($sformatf("rnd%0d", i), model(s, a, b));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
